// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants, state encoding and helpers for the ADC conversion sequencer
package adc_pkg;

  localparam int RESULT_W     = 16;
  localparam int AVG_LOG2_MAX = 4;
  localparam int ACC_W        = RESULT_W + AVG_LOG2_MAX;
  localparam int CNT_W        = AVG_LOG2_MAX + 1;
  localparam int TIMER_W      = 16;

  localparam logic [TIMER_W-1:0] TIMEOUT_CYC = 16'd1023;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_OUTPUT,
    ST_GAP
  } seq_state_t;

  function automatic logic [2:0] clamp_avg_log2(input logic [2:0] n);
    return (n > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : n;
  endfunction

  // Index of the final sample in a burst of 2^n conversions.
  function automatic logic [CNT_W-1:0] burst_last(input logic [2:0] n);
    logic [CNT_W-1:0] one;
    one = 1;
    return (one << n) - one;
  endfunction

endpackage

// File: rtl/adc_conv_sequencer_if.sv
// rtl/adc_conv_sequencer_if.sv - averaged-result valid/ready handshake toward the readout side
interface adc_conv_sequencer_if;
  import adc_pkg::*;

  logic [RESULT_W-1:0] avg_result_out;
  logic                avg_valid_out;
  logic                avg_ready_in;

  modport master (
    output avg_result_out,
    output avg_valid_out,
    input  avg_ready_in
  );

  modport slave (
    input  avg_result_out,
    input  avg_valid_out,
    output avg_ready_in
  );

endinterface

// File: rtl/adc_seq_timer.sv
// rtl/adc_seq_timer.sv - clearable up-counter with terminal compare, shared by WAIT timeout and GAP interval
module adc_seq_timer
  import adc_pkg::*;
(
  input  logic               clk_vcm,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic [TIMER_W-1:0] term,
  output logic               hit
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk_vcm or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == term);

endmodule

// File: rtl/adc_conv_sequencer.sv
// rtl/adc_conv_sequencer.sv - issues ADC start pulses, averages 2^N results per burst, hands the mean out
module adc_conv_sequencer
  import adc_pkg::*;
(
  input  logic                clk_vcm,
  input  logic                rst_n,
  input  logic                enable_in,
  input  logic                single_shot_in,
  input  logic [2:0]          avg_log2_in,
  input  logic [15:0]         interval_in,
  output logic                start_conversion_out,
  input  logic [RESULT_W-1:0] adc_result_in,
  input  logic                adc_finished_in,
  output logic                busy_out,
  output logic                timeout_err_out,
  input  logic                err_clr_in,
  adc_conv_sequencer_if.master avg_if
);

  seq_state_t         state;
  logic               finished_q;
  logic               fin_evt;
  logic [2:0]         n_q;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cnt;
  logic [TIMER_W-1:0] gap_term;
  logic               handshake;
  logic               tmr_clr;
  logic               tmr_inc;
  logic               tmr_hit;
  logic [TIMER_W-1:0] tmr_term;

  assign fin_evt   = adc_finished_in & ~finished_q;
  assign acc_sum   = acc + ACC_W'(adc_result_in);
  assign handshake = avg_if.avg_valid_out & avg_if.avg_ready_in;

  // The timer restarts on every start pulse and again on the handshake that enters GAP.
  assign tmr_clr  = (state == ST_START) || ((state == ST_OUTPUT) && handshake);
  assign tmr_inc  = (state == ST_WAIT) || (state == ST_GAP);
  assign tmr_term = (state == ST_GAP) ? gap_term : TIMEOUT_CYC;

  adc_seq_timer u_timer (
    .clk_vcm (clk_vcm),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .term    (tmr_term),
    .hit     (tmr_hit)
  );

  always_ff @(posedge clk_vcm or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= ST_IDLE;
      finished_q            <= 1'b0;
      n_q                   <= '0;
      acc                   <= '0;
      cnt                   <= '0;
      gap_term              <= '0;
      start_conversion_out  <= 1'b0;
      busy_out              <= 1'b0;
      timeout_err_out       <= 1'b0;
      avg_if.avg_result_out <= '0;
      avg_if.avg_valid_out  <= 1'b0;
    end else begin
      finished_q           <= adc_finished_in;
      start_conversion_out <= 1'b0;
      if (err_clr_in) begin
        timeout_err_out <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          if (enable_in || single_shot_in) begin
            n_q                  <= clamp_avg_log2(avg_log2_in);
            acc                  <= '0;
            cnt                  <= '0;
            start_conversion_out <= 1'b1;
            busy_out             <= 1'b1;
            state                <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fin_evt) begin
            acc <= acc_sum;
            cnt <= cnt + 1'b1;
            if (cnt == burst_last(n_q)) begin
              avg_if.avg_result_out <= RESULT_W'(acc_sum >> n_q);
              avg_if.avg_valid_out  <= 1'b1;
              state                 <= ST_OUTPUT;
            end else begin
              start_conversion_out <= 1'b1;
              state                <= ST_START;
            end
          end else if (tmr_hit) begin
            // Placed after the clear so a coincident new timeout keeps the flag set.
            timeout_err_out <= 1'b1;
            busy_out        <= 1'b0;
            state           <= ST_IDLE;
          end
        end
        ST_OUTPUT: begin
          if (handshake) begin
            avg_if.avg_valid_out <= 1'b0;
            gap_term <= (interval_in == '0) ? '0 : interval_in - 1'b1;
            if (enable_in) begin
              state <= ST_GAP;
            end else begin
              busy_out <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (!enable_in) begin
            busy_out <= 1'b0;
            state    <= ST_IDLE;
          end else if (tmr_hit) begin
            acc                  <= '0;
            cnt                  <= '0;
            start_conversion_out <= 1'b1;
            state                <= ST_START;
          end
        end
        default: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
